kersram_rd_ctrl: RTL and testbench
==================================

# kersram_rd_ctrl

Read sequencer for the eight kernel SRAM banks (KER_SRAM, 2048 x 64 each). On `start_ker_read` it issues same-address reads to all eight banks over a programmed window, repeating the window a programmed number of passes. Each read returns one 512-bit kernel beat to the PE array through a valid/ready port with backpressure. It sits beside `kersram_w`, owns the bank ports while busy, and mirrors the writer's start/busy/done handshake.

## Interface
- `BANKS`, default 8: number of kernel banks read in parallel.
- `ADDR_W`, default 11: bank address width (depth 2048).
- `DATA_W`, default 64: bank word width.
- `FIFO_D`, default 4: return-buffer depth in beats; must be a power of two, 4 or more.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start_ker_read`, in, 1: start request; sampled only in IDLE.
- `base_addr`, in, ADDR_W: first address of the window; sampled with start.
- `len_m1`, in, ADDR_W: words per pass minus 1; sampled with start.
- `rep_m1`, in, 8: passes minus 1; sampled with start.
- `ker_read_busy`, out, 1: high from the cycle after an accepted start through the DONE cycle.
- `ker_read_done`, out, 1: one-cycle pulse.
- `cen_kersr`, out, 1: shared active-low chip enable for all banks.
- `wen_kersr`, out, 1: shared active-low write enable; constant 1.
- `addr__kersr`, out, ADDR_W: shared address.
- `dout_kersr`, in, BANKS*DATA_W: bank Q outputs concatenated, bank 0 in the LSBs.
- `ker_beat_data`, out, BANKS*DATA_W: head of the return buffer.
- `ker_beat_valid`, out, 1: return buffer not empty.
- `ker_beat_ready`, in, 1: consumer accepts the beat when valid and ready are both high.
- `ker_rd_stall_cnt`, out, 16: present only with KERSRAM_RD_STALL_CNT_EN.

## Operation
- States:
  - IDLE -> RUN on `start_ker_read`.
  - RUN -> DRAIN after the last read of the last pass is issued.
  - DRAIN -> DONE when no read is pending and the buffer is empty.
  - DONE -> IDLE unconditionally.
- Issue rule in RUN: `cen_kersr`=0 when `fifo_cnt + pend < FIFO_D`. `pend` is 1 if a read was issued in the previous cycle. The rule deliberately ignores a same-cycle pop.
- Address counter:
  - Starts at `base_addr`.
  - Increments modulo 2^ADDR_W, so it wraps 2047 -> 0.
  - Reloads `base_addr` at the end of each pass.
- Word counter runs 0..`len_m1`. Pass counter runs 0..`rep_m1`.
- The return buffer is written with `dout_kersr` in the cycle after each issue (SRAM latency 1). The buffer never overflows.
- `wen_kersr` stays 1 at all times; the block never writes.
- When not issuing, `cen_kersr`=1 and `addr__kersr` holds its last value.
- `start_ker_read` in any state other than IDLE is ignored.
- A simultaneous push and pop leaves `fifo_cnt` unchanged.
- `reset` in any state, including mid-pass:
  - returns the block to IDLE;
  - flushes the buffer and clears `pend` and all counters;
  - no partial beat is emitted after reset.
- Reset values of outputs: `busy`=0, `done`=0, `cen_kersr`=1, `wen_kersr`=1, `addr__kersr`=0, `ker_beat_valid`=0, `ker_beat_data`=0 (buffer storage is cleared), `ker_rd_stall_cnt`=0.

## Timing
- Cycle 0: `start_ker_read` is high in IDLE.
- Cycle 1: RUN, `busy`=1, `cen_kersr`=0, `addr__kersr`=base.
- Cycle 2: Q is valid and is pushed at the end of the cycle.
- Cycle 3: `ker_beat_valid`=1.
- Throughput is one beat per cycle while `ker_beat_ready` stays high.
- Total beats = (`len_m1`+1)*(`rep_m1`+1), delivered in address order and pass order.
- `done` pulses in the cycle after the final beat handshake. `busy` falls in the cycle after `done`.
- Minimum job (1 word, 1 pass): start in cycle 0, beat in cycle 3, `done` in cycle 4 when ready is held high.

## Configuration
- `KERSRAM_RD_STALL_CNT_EN` defined:
  - `ker_rd_stall_cnt` increments, saturating at 0xFFFF, in every cycle with valid=1 and ready=0;
  - it clears on an accepted start and on reset.
- `KERSRAM_RD_STALL_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `ker_pkg` holds:
  - the shared constants KER_BANKS=8, KER_ADDR_W=11, KER_DATA_W=64;
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the beat width KER_BEAT_W = KER_BANKS*KER_DATA_W.
- One sub-module, `ker_beat_fifo`: a synchronous FIFO_D x 512-bit FIFO with push, pop, count and valid, cleared by `reset`.
- FSM, counters and issue logic live in `kersram_rd_ctrl`.

## Test plan
- Basic job:
  - Stimulus: banks preloaded with word = {bank, addr}; base=0x010, len_m1=3, rep_m1=0; ready held high.
  - Response: beats addr 0x010..0x013 in cycles 3..6; `done` in cycle 7; `cen_kersr` low in cycles 1..4 only.
- Wrap and repeat:
  - Stimulus: base=0x7FE, len_m1=2, rep_m1=1.
  - Response: 6 beats at addr 0x7FE, 0x7FF, 0x000, 0x7FE, 0x7FF, 0x000.
- Backpressure:
  - Stimulus: len_m1=15; ready low for cycles 4..13.
  - Response: at most 4 reads outstanding; `cen_kersr` stays 1 while the buffer is full; all 16 beats arrive in order with no loss or duplication; stall count = 10 with the macro defined.
- Start while busy:
  - Stimulus: second start with base=0x100 in cycle 2 of a running job.
  - Response: ignored; the original sequence completes unchanged.
- Reset mid-job:
  - Stimulus: reset in cycle 5 of a len_m1=15 job.
  - Response: in the next cycle `busy`=0, `valid`=0, `cen_kersr`=1, no `done` pulse; a new job run afterwards completes normally.
- Minimum job:
  - Stimulus: len_m1=0, rep_m1=0.
  - Response: exactly one beat in cycle 3; `done` in cycle 4; `busy` high in cycles 1..4.

Source files
------------

// File: rtl/ker_pkg.sv
// ker_pkg: shared constants and types for the kernel SRAM read sequencer.
//   KER_BANKS / KER_ADDR_W / KER_DATA_W : bank count, bank address width, bank word width
//   KER_BEAT_W                          : width of one beat (all banks side by side)
//   ker_state_e                         : sequencer FSM states
package ker_pkg;

   localparam int unsigned KER_BANKS  = 8;
   localparam int unsigned KER_ADDR_W = 11;
   localparam int unsigned KER_DATA_W = 64;
   localparam int unsigned KER_BEAT_W = KER_BANKS * KER_DATA_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ker_state_e;

endpackage

// File: rtl/ker_beat_fifo.sv
// ker_beat_fifo: synchronous return buffer for kernel beats.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (also clears storage)
//   push, push_data     : write one beat (caller guarantees the buffer is not full)
//   pop                 : drop the head beat (ignored while empty)
//   pop_data            : head beat
//   count               : beats currently stored (0..DEPTH)
//   valid               : buffer not empty
module ker_beat_fifo
   import ker_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = KER_BEAT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     valid
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_pop;

   assign valid    = (count != '0);
   assign do_pop   = pop & valid;
   assign pop_data = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, do_pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/kersram_rd_ctrl.sv
// kersram_rd_ctrl: read sequencer for the kernel SRAM banks.
// Issues same-address reads to all banks over a window [base_addr, base_addr+len_m1]
// (mod 2^ADDR_W), repeated rep_m1+1 times, and returns each beat through a
// valid/ready port backed by a small return buffer.
// Ports:
//   clk, reset                        : clock, synchronous active-high reset
//   start_ker_read                    : job start, sampled only in IDLE
//   base_addr, len_m1, rep_m1         : job window and pass count, sampled with start
//   ker_read_busy, ker_read_done      : job in progress / one-cycle completion pulse
//   cen_kersr, wen_kersr, addr__kersr : shared bank controls (active-low, never writes)
//   dout_kersr                        : bank read data, bank 0 in the LSBs
//   ker_beat_data/valid/ready         : beat output port
//   ker_rd_stall_cnt                  : backpressure cycle count, only with
//                                       KERSRAM_RD_STALL_CNT_EN defined
module kersram_rd_ctrl
   import ker_pkg::*;
#(
   parameter int unsigned BANKS  = KER_BANKS,
   parameter int unsigned ADDR_W = KER_ADDR_W,
   parameter int unsigned DATA_W = KER_DATA_W,
   parameter int unsigned FIFO_D = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start_ker_read,
   input  logic [ADDR_W-1:0]         base_addr,
   input  logic [ADDR_W-1:0]         len_m1,
   input  logic [7:0]                rep_m1,
   output logic                      ker_read_busy,
   output logic                      ker_read_done,
   output logic                      cen_kersr,
   output logic                      wen_kersr,
   output logic [ADDR_W-1:0]         addr__kersr,
   input  logic [BANKS*DATA_W-1:0]   dout_kersr,
   output logic [BANKS*DATA_W-1:0]   ker_beat_data,
   output logic                      ker_beat_valid,
   input  logic                      ker_beat_ready
`ifdef KERSRAM_RD_STALL_CNT_EN
   ,
   output logic [15:0]               ker_rd_stall_cnt
`endif
);

   localparam int unsigned   BEAT_W   = BANKS * DATA_W;
   localparam int unsigned   CNT_W    = $clog2(FIFO_D) + 1;
   localparam logic [CNT_W:0] FIFO_LIM = (CNT_W + 1)'(FIFO_D);

   ker_state_e        state;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] len_q;
   logic [7:0]        rep_q;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] last_addr;
   logic [ADDR_W-1:0] word_cnt;
   logic [7:0]        pass_cnt;
   logic              pend;

   logic [CNT_W-1:0]  fifo_cnt;
   logic              fifo_valid;
   logic              pop;
   logic              issue;
   logic              last_word;
   logic              last_pass;
   logic              drained;
   logic [CNT_W:0]    occ;

   // Occupancy counts buffered beats plus the read in flight; a same-cycle pop is
   // deliberately not credited, so the buffer can never overflow.
   assign occ       = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, pend};
   assign issue     = (state == RUN) && !reset && (occ < FIFO_LIM);
   assign pop       = fifo_valid & ker_beat_ready;
   assign last_word = (word_cnt == len_q);
   assign last_pass = (pass_cnt == rep_q);
   // Last beat is either gone or leaving this cycle, so DONE lands right after it.
   assign drained   = !pend && ((fifo_cnt == '0) || ((fifo_cnt == CNT_W'(1)) && pop));

   assign cen_kersr      = ~issue;
   assign wen_kersr      = 1'b1;
   assign addr__kersr    = issue ? ptr : last_addr;
   assign ker_beat_valid = fifo_valid;
   assign ker_read_busy  = (state != IDLE);
   assign ker_read_done  = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         base_q    <= '0;
         len_q     <= '0;
         rep_q     <= '0;
         ptr       <= '0;
         last_addr <= '0;
         word_cnt  <= '0;
         pass_cnt  <= '0;
         pend      <= 1'b0;
      end else begin
         pend <= issue;
         case (state)
            IDLE: begin
               if (start_ker_read) begin
                  base_q   <= base_addr;
                  len_q    <= len_m1;
                  rep_q    <= rep_m1;
                  ptr      <= base_addr;
                  word_cnt <= '0;
                  pass_cnt <= '0;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (issue) begin
                  last_addr <= ptr;
                  if (last_word) begin
                     word_cnt <= '0;
                     ptr      <= base_q;
                     if (last_pass) begin
                        state <= DRAIN;
                     end else begin
                        pass_cnt <= pass_cnt + 8'd1;
                     end
                  end else begin
                     word_cnt <= word_cnt + ADDR_W'(1);
                     ptr      <= ptr + ADDR_W'(1);
                  end
               end
            end
            DRAIN: begin
               if (drained) begin
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // SRAM latency is one cycle: the read issued last cycle lands now.
   ker_beat_fifo #(
      .DEPTH (FIFO_D),
      .WIDTH (BEAT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (pend),
      .push_data (dout_kersr),
      .pop       (pop),
      .pop_data  (ker_beat_data),
      .count     (fifo_cnt),
      .valid     (fifo_valid)
   );

`ifdef KERSRAM_RD_STALL_CNT_EN
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else if ((state == IDLE) && start_ker_read) begin
         stall_cnt_q <= '0;
      end else if (fifo_valid && !ker_beat_ready && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_q <= stall_cnt_q + 16'd1;
      end
   end

   assign ker_rd_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_kersram_rd_ctrl.sv
// tb_kersram_rd_ctrl: self-checking bench for kersram_rd_ctrl.
// A table of jobs (window, passes, backpressure, stray start) is applied in a loop;
// expected beats go to a scoreboard queue at job start and are popped on handshake.
// Reset state and a mid-job reset are covered by hand-written sequences.
module tb_kersram_rd_ctrl;
   import ker_pkg::*;

   localparam int unsigned BW = KER_BEAT_W;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [10:0]   base;
   logic [10:0]   len;
   logic [7:0]    rep;
   logic          rdy;
   logic          busy;
   logic          done;
   logic          cen;
   logic          wen;
   logic [10:0]   addr;
   logic [BW-1:0] dout = '0;
   logic [BW-1:0] bdata;
   logic          bvalid;
`ifdef KERSRAM_RD_STALL_CNT_EN
   logic [15:0]   stall_cnt;
`endif

   int n_vec  = 0;
   int n_miss = 0;

   logic [BW-1:0] sbq[$];

   typedef struct {
      logic [10:0] base;
      logic [10:0] len_m1;
      logic [7:0]  rep_m1;
      int          rdy_lo_first;
      int          rdy_lo_last;
      int          start2_at;
      int          exp_first_beat;
      int          exp_done;
      int          exp_cen_last;
      int          exp_stall;
   } vec_t;

   vec_t tbl[6];

   always #5 clk = ~clk;

   kersram_rd_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .start_ker_read   (start),
      .base_addr        (base),
      .len_m1           (len),
      .rep_m1           (rep),
      .ker_read_busy    (busy),
      .ker_read_done    (done),
      .cen_kersr        (cen),
      .wen_kersr        (wen),
      .addr__kersr      (addr),
      .dout_kersr       (dout),
      .ker_beat_data    (bdata),
      .ker_beat_valid   (bvalid),
      .ker_beat_ready   (rdy)
`ifdef KERSRAM_RD_STALL_CNT_EN
      ,
      .ker_rd_stall_cnt (stall_cnt)
`endif
   );

   // Bank contents: word = {bank, addr}.
   function automatic logic [BW-1:0] beat_of(input logic [10:0] a);
      logic [BW-1:0] r;
      for (int b = 0; b < int'(KER_BANKS); b++) begin
         r[b*64 +: 64] = {32'(b), 21'd0, a};
      end
      return r;
   endfunction

   // SRAM model, one-cycle read latency.
   always @(posedge clk) begin
      if (!cen) dout <= beat_of(addr);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic chkd(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int n_exp;
      int issued, accepted, ncen, cen_last, first_beat, done_c, ndone;
      int viol, wen_bad, busy_c1, busy_after, nbeat;
      bit fin;
      string tag;
      logic [BW-1:0] e;
      tag        = $sformatf("v%0d", idx);
      n_exp      = (int'(v.len_m1) + 1) * (int'(v.rep_m1) + 1);
      issued     = 0;
      accepted   = 0;
      ncen       = 0;
      cen_last   = -1;
      first_beat = -1;
      done_c     = -1;
      ndone      = 0;
      viol       = 0;
      wen_bad    = 0;
      busy_c1    = 0;
      busy_after = 1;
      nbeat      = 0;
      fin        = 1'b0;
      for (int p = 0; p <= int'(v.rep_m1); p++) begin
         for (int w = 0; w <= int'(v.len_m1); w++) begin
            sbq.push_back(beat_of(11'(int'(v.base) + w)));
         end
      end
      for (int c = 0; c < 300 && !fin; c++) begin
         start = (c == 0) || (c == v.start2_at);
         base  = (c == 0) ? v.base : 11'h100;
         len   = v.len_m1;
         rep   = v.rep_m1;
         rdy   = !(c >= v.rdy_lo_first && c <= v.rdy_lo_last);
         #1;
         if (c == 1) busy_c1 = int'(busy);
         if (done_c >= 0 && c == done_c + 1) begin
            busy_after = int'(busy);
            fin        = 1'b1;
         end
         if (wen !== 1'b1) wen_bad++;
         if (!cen) begin
            if (issued - accepted >= 4) viol++;
            issued++;
            ncen++;
            cen_last = c;
         end
         if (bvalid && rdy) begin
            accepted++;
            if (first_beat < 0) first_beat = c;
            if (sbq.size() == 0) begin
               chk({tag, " extra_beat"}, 64'(accepted), 64'(n_exp));
            end else begin
               e = sbq.pop_front();
               chkd($sformatf("%s beat%0d", tag, nbeat), bdata, e);
            end
            nbeat++;
         end
         if (done) begin
            ndone++;
            done_c = c;
         end
         tick();
      end
      start = 1'b0;
      chk({tag, " finished"}, 64'(fin), 64'd1);
      chk({tag, " first_beat_cycle"}, 64'(first_beat), 64'(v.exp_first_beat));
      chk({tag, " done_cycle"}, 64'(done_c), 64'(v.exp_done));
      chk({tag, " done_pulses"}, 64'(ndone), 64'd1);
      chk({tag, " cen_last_cycle"}, 64'(cen_last), 64'(v.exp_cen_last));
      chk({tag, " cen_low_cycles"}, 64'(ncen), 64'(n_exp));
      chk({tag, " beats"}, 64'(accepted), 64'(n_exp));
      chk({tag, " sb_left"}, 64'(sbq.size()), 64'd0);
      chk({tag, " outstanding_over_4"}, 64'(viol), 64'd0);
      chk({tag, " wen_not_1"}, 64'(wen_bad), 64'd0);
      chk({tag, " busy_cycle1"}, 64'(busy_c1), 64'd1);
      chk({tag, " busy_after_done"}, 64'(busy_after), 64'd0);
`ifdef KERSRAM_RD_STALL_CNT_EN
      chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'(v.exp_stall));
`endif
      sbq.delete();
   endtask

   initial begin
      int nd, nv;
      // base, len_m1, rep_m1, rdy_lo_first, rdy_lo_last, start2_at,
      // first beat, done, last cen-low cycle, stall count
      tbl[0] = '{11'h010, 11'd3,  8'd0, -1, -1, -1, 3, 7,  4,  0};   // basic
      tbl[1] = '{11'h7FE, 11'd2,  8'd1, -1, -1, -1, 3, 9,  6,  0};   // wrap + repeat
      tbl[2] = '{11'h040, 11'd15, 8'd0,  4, 13, -1, 3, 29, 25, 10};  // backpressure
      tbl[3] = '{11'h020, 11'd3,  8'd0, -1, -1,  2, 3, 7,  4,  0};   // start while busy
      tbl[4] = '{11'h005, 11'd0,  8'd0, -1, -1, -1, 3, 4,  1,  0};   // minimum job
      tbl[5] = '{11'h3FF, 11'd1,  8'd2, -1, -1, -1, 3, 9,  6,  0};   // three passes

      reset = 1'b1;
      start = 1'b0;
      base  = '0;
      len   = '0;
      rep   = '0;
      rdy   = 1'b1;
      repeat (3) tick();
      chk("rst busy",  64'(busy),   64'd0);
      chk("rst done",  64'(done),   64'd0);
      chk("rst cen",   64'(cen),    64'd1);
      chk("rst wen",   64'(wen),    64'd1);
      chk("rst addr",  64'(addr),   64'd0);
      chk("rst valid", 64'(bvalid), 64'd0);
      chkd("rst data", bdata, '0);
`ifdef KERSRAM_RD_STALL_CNT_EN
      chk("rst stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_vec(i, tbl[i]);
      end

      // Reset in cycle 5 of a 16-word job.
      start = 1'b1;
      base  = 11'h080;
      len   = 11'd15;
      rep   = 8'd0;
      rdy   = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("midrst busy",  64'(busy),   64'd0);
      chk("midrst valid", 64'(bvalid), 64'd0);
      chk("midrst cen",   64'(cen),    64'd1);
      chk("midrst done",  64'(done),   64'd0);
      chkd("midrst data", bdata, '0);
      nd = 0;
      nv = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (done) nd++;
         if (bvalid) nv++;
      end
      chk("midrst late_done",  64'(nd), 64'd0);
      chk("midrst late_valid", 64'(nv), 64'd0);

      run_vec(6, tbl[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
